// File: rtl/peripheral_display_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_display_pkg
// Shared types and constants for the 7-segment display scanner.
//   scan_state_t : two-state scan FSM (BLANK gap / SHOW digit)
//   BLANK_CODE   : {EXT,D} code the downstream decoder turns into all-off
//   digit_t      : one stored digit {blink, ext, d}
//   apply_blink  : returns the code to present for a digit given blink phase
// ---------------------------------------------------------------------------
package peripheral_display_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [4:0] BLANK_CODE = 5'b1_0000;

    typedef struct packed {
        logic       blink;
        logic       ext;
        logic [3:0] d;
    } digit_t;

    localparam digit_t DIGIT_RESET = '{blink: 1'b0,
                                       ext:   BLANK_CODE[4],
                                       d:     BLANK_CODE[3:0]};

    // During the "off" half of the blink period a blinking digit is replaced
    // by the blank code; non-blinking digits are passed through untouched.
    function automatic logic [4:0] apply_blink(input digit_t dg, input logic phase);
        return (phase && dg.blink) ? BLANK_CODE : {dg.ext, dg.d};
    endfunction

endpackage

// File: rtl/peripheral_prescaler.sv
// ---------------------------------------------------------------------------
// peripheral_prescaler
// Free-running modulo-DIV counter with synchronous clear.
// Ports:
//   CLK      in  system clock (rising edge)
//   RESET_N  in  asynchronous active-low reset
//   CLR      in  synchronous clear; holds the count at 0 while high
//   TC       out terminal count, high while the count equals DIV-1
// ---------------------------------------------------------------------------
module peripheral_prescaler #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLR,
    output logic TC
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (CLR || TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TC = (cnt == LAST);

endmodule

// File: rtl/peripheral_display_scan.sv
// ---------------------------------------------------------------------------
// peripheral_display_scan
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// Stores one {BLINK,EXT,D} code per digit and, slot by slot, presents one
// code to the downstream decoder while driving the matching active-low anode.
// Each slot is one BLANK cycle (all anodes off, code loaded) followed by
// CLK_DIV SHOW cycles (one anode on, code held stable).
// Ports:
//   CLK       in   system clock (rising edge)
//   RESET_N   in   asynchronous active-low reset
//   ENABLE    in   1 = scan, 0 = anodes off, scanner parked at digit 0
//   WR_EN     in   write strobe
//   WR_ADDR   in   digit index to write (indices >= N_DIGITS ignored)
//   WR_DATA   in   {BLINK,EXT,D[3:0]} for digit WR_ADDR
//   D         out  nibble to the decoder
//   EXTENDED  out  extended-glyph select to the decoder
//   AN        out  anode enables, active-low, one-hot-low while showing
//   FRAME     out  one-cycle pulse after the last digit's slot ends
// Write interface: WR_EN is a single-cycle strobe with no back-pressure; every
// cycle it is sampled high the addressed register is updated on that edge.
// The new value reaches the outputs only at the next BLANK load of that
// digit, so a code never changes in the middle of a lit slot.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module peripheral_display_scan
    import peripheral_display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64,
    localparam int IDX_W       = $clog2(N_DIGITS)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ENABLE,
    input  logic                WR_EN,
    input  logic [IDX_W-1:0]    WR_ADDR,
    input  logic [5:0]          WR_DATA,
    output logic [3:0]          D,
    output logic                EXTENDED,
    output logic [N_DIGITS-1:0] AN,
    output logic                FRAME
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0]    LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W:0]   N_DIG_EXT  = (IDX_W + 1)'(N_DIGITS);

    scan_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [FW-1:0]    fcnt;
    logic             phase;
    digit_t           digits [N_DIGITS];

    logic             slot_tc;
    logic [4:0]       load_code;
    logic             addr_ok;
    logic [N_DIGITS-1:0] an_sel;

    // The slot counter only runs while a digit is lit; BLANK and disable
    // both hold it at 0 so every SHOW starts from a fresh count.
    peripheral_prescaler #(
        .DIV (CLK_DIV)
    ) u_slot (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLR     ((state != S_SHOW) || !ENABLE),
        .TC      (slot_tc)
    );

    assign load_code = apply_blink(digits[idx], phase);
    assign addr_ok   = ({1'b0, WR_ADDR} < N_DIG_EXT);
    assign an_sel    = ~(N_DIGITS'(1) << idx);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_BLANK;
            idx      <= '0;
            fcnt     <= '0;
            phase    <= 1'b0;
            D        <= BLANK_CODE[3:0];
            EXTENDED <= BLANK_CODE[4];
            AN       <= '1;
            FRAME    <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                digits[i] <= DIGIT_RESET;
            end
        end else begin
            FRAME <= 1'b0;

            // The load below reads the pre-edge register, so a write landing
            // on the same edge as its digit's load is seen only next frame.
            if (WR_EN && addr_ok) begin
                digits[WR_ADDR] <= digit_t'(WR_DATA);
            end

            if (state == S_BLANK) begin
                {EXTENDED, D} <= load_code;
            end

            if (!ENABLE) begin
                state <= S_BLANK;
                idx   <= '0;
                AN    <= '1;
            end else begin
                case (state)
                    S_BLANK: begin
                        state <= S_SHOW;
                        AN    <= an_sel;
                    end
                    S_SHOW: begin
                        if (slot_tc) begin
                            state <= S_BLANK;
                            AN    <= '1;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                FRAME <= 1'b1;
                                // Phase flips together with the FRAME pulse so
                                // the whole next frame sees one consistent phase.
                                if (fcnt == LAST_FRAME) begin
                                    fcnt  <= '0;
                                    phase <= ~phase;
                                end else begin
                                    fcnt <= fcnt + 1'b1;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_BLANK;
                        AN    <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_peripheral_display_scan.sv
// ---------------------------------------------------------------------------
// tb_peripheral_display_scan
// Self-checking bench for peripheral_display_scan with N_DIGITS=4, CLK_DIV=4,
// BLINK_FRAMES=2. A monitor sampling on the falling edge tracks every slot:
// it pops the expected {AN,EXT,D} at the start of each lit slot, and checks
// slot length, the single-cycle anode gap, code stability within a slot and
// the FRAME period. Hand-written sequences cover writes at slot boundaries,
// disable/re-enable and reset in the middle of a slot.
// ---------------------------------------------------------------------------
module tb_peripheral_display_scan;

    localparam int NDIG   = 4;
    localparam int DIV    = 4;
    localparam int BF     = 2;
    localparam int SLOT   = DIV + 1;
    localparam int FRAMEL = NDIG * SLOT;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] d;
    logic       ext;
    logic [3:0] an;
    logic       frame;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    peripheral_display_scan #(
        .N_DIGITS     (NDIG),
        .CLK_DIV      (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .ENABLE   (enable),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .D        (d),
        .EXTENDED (ext),
        .AN       (an),
        .FRAME    (frame)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];   // {an[3:0], ext, d[3:0]} per lit slot

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] addr;
        logic [5:0] data;
        logic [3:0] an;
        logic       ext;
        logic [3:0] d;
    } vec_t;

    vec_t vecs[NDIG];

    task automatic push_frame(input int blank_digit);
        for (int i = 0; i < NDIG; i++) begin
            if (i == blank_digit) exp_q.push_back({vecs[i].an, 1'b1, 4'h0});
            else                  exp_q.push_back({vecs[i].an, vecs[i].ext, vecs[i].d});
        end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wr(input logic [1:0] a, input logic [5:0] v);
        wr_addr = a;
        wr_data = v;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (an !== target && k < 200);
        if (an !== target) check(name, an, target);
    endtask

    task automatic wait_frame(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame !== 1'b1 && k < 200);
        if (frame !== 1'b1) check(name, frame, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_on;
    int         cyc, last_frame_cyc, blank_len, show_len;
    logic       in_show, seen_show;
    logic [3:0] s_an, s_d;
    logic       s_ext;
    logic [8:0] exp_v;

    always @(negedge clk) begin
        if (!mon_on) begin
            cyc            = 0;
            last_frame_cyc = -1;
            blank_len      = 0;
            show_len       = 0;
            in_show        = 1'b0;
            seen_show      = 1'b0;
        end else begin
            cyc++;
            if (an === 4'b1111) begin
                if (in_show) begin
                    check("slot_len", show_len, DIV);
                    in_show = 1'b0;
                end
                blank_len++;
            end else begin
                if (!in_show) begin
                    if (seen_show) check("gap_len", blank_len, 1);
                    if (exp_q.size() > 0) begin
                        exp_v = exp_q.pop_front();
                        check("sb_slot", {an, ext, d}, exp_v);
                    end
                    s_an      = an;
                    s_d       = d;
                    s_ext     = ext;
                    in_show   = 1'b1;
                    seen_show = 1'b1;
                    blank_len = 0;
                    show_len  = 0;
                end else begin
                    check("slot_stable", {an, ext, d}, {s_an, s_ext, s_d});
                end
                show_len++;
            end
            if (frame === 1'b1) begin
                if (last_frame_cyc >= 0) check("frame_period", cyc - last_frame_cyc, FRAMEL);
                last_frame_cyc = cyc;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{addr: 2'd0, data: 6'h03, an: 4'b1110, ext: 1'b0, d: 4'h3};
        vecs[1] = '{addr: 2'd1, data: 6'h01, an: 4'b1101, ext: 1'b0, d: 4'h1};
        vecs[2] = '{addr: 2'd2, data: 6'h1C, an: 4'b1011, ext: 1'b1, d: 4'hC};
        vecs[3] = '{addr: 2'd3, data: 6'h05, an: 4'b0111, ext: 1'b0, d: 4'h5};

        rst_n   = 1'b0;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        mon_on  = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_an", an, 4'b1111);
        check("rst_ext", ext, 1'b1);
        check("rst_d", d, 4'h0);
        check("rst_frame", frame, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic scan of the table, two frames
        for (int i = 0; i < NDIG; i++) wr(vecs[i].addr, vecs[i].data);
        mon_on = 1'b1;
        push_frame(-1);
        push_frame(-1);
        enable = 1'b1;
        wait_drain("t2_drain", 3 * FRAMEL);

        // valid address with WR_EN low must not change anything
        wr_addr = 2'd2;
        wr_data = 6'h0F;
        wait_frame("t4_frame");
        push_frame(-1);
        wait_drain("t4_drain", 2 * FRAMEL);
        wr_addr = 2'd1;
        wait_frame("t4_frame2");
        push_frame(-1);
        wait_drain("t4_drain2", 2 * FRAMEL);

        // write to digit 2 while it is lit: held until the next frame
        wait_an(4'b1011, "t3_find_show");
        wr(2'd2, 6'h0A);
        check("t3_hold_d", d, 4'hC);
        check("t3_hold_ext", ext, 1'b1);
        wait_an(4'b1111, "t3_gap");
        wait_an(4'b1011, "t3_next");
        check("t3_new_d", d, 4'hA);
        check("t3_new_ext", ext, 1'b0);

        // write on digit 2's BLANK load cycle: old value is shown
        wait_an(4'b1101, "t3_find_d1");
        wait_an(4'b1111, "t3_find_blank");
        wr(2'd2, 6'h07);
        check("t3_blank_an", an, 4'b1011);
        check("t3_blank_old", d, 4'hA);
        wait_an(4'b1111, "t3_gap2");
        wait_an(4'b1011, "t3_next2");
        check("t3_blank_new", d, 4'h7);

        // disable during digit 2, then re-enable
        wait_an(4'b1011, "t6_find");
        mon_on = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("t6_off_an", an, 4'b1111);
        repeat (3) @(negedge clk);
        check("t6_held_an", an, 4'b1111);
        check("t6_held_frame", frame, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check("t6_reen_an", an, 4'b1110);
        check("t6_reen_d", d, 4'h3);

        // reset in the middle of a lit slot
        wait_an(4'b1101, "t1_find");
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_an", an, 4'b1111);
        check("t1_async_ext", ext, 1'b1);
        check("t1_async_d", d, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_first_an", an, 4'b1110);
        check("t1_first_code", {ext, d}, 5'b1_0000);

        // blink: digit 1 blanked on frames 2 and 3 only
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDIG; i++) begin
            wr(vecs[i].addr, (i == 1) ? (vecs[i].data | 6'h20) : vecs[i].data);
        end
        mon_on = 1'b1;
        for (int f = 0; f < 6; f++) push_frame((f == 2 || f == 3) ? 1 : -1);
        enable = 1'b1;
        wait_drain("t5_drain", 7 * FRAMEL);
        repeat ($urandom_range(SLOT, 2 * SLOT)) @(negedge clk);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
